// File: rtl/color_pkg.sv
// Colour types shared across the renderer.
// 12-bit colour packed as {r,g,b}, 4 bits per channel.
// No logic; types only.
package color_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color12_t;

endpackage

// File: rtl/fixed_pkg.sv
// Fixed-point numeric types shared across the renderer.
// Q16.16 signed scalar and a 2-D point built from two of them.
// No logic; types only.
package fixed_pkg;

    typedef logic signed [31:0] q16_16_t;

    typedef struct packed {
        q16_16_t x;
        q16_16_t y;
    } point2d_t;

endpackage

// File: rtl/render_pkg.sv
// Renderer-wide scheduler state, depth constants and framebuffer defaults.
// Reuses fixed_pkg/color_pkg types; defines no new numeric types.
// Helper converts a framebuffer coordinate into a Q16.16 screen coordinate.
package render_pkg;
    import fixed_pkg::*;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_ISSUE,
        RS_DRAIN,
        RS_WRITE,
        RS_FINISH
    } raster_state_t;

    // Farthest representable depth: any covering triangle is nearer.
    localparam q16_16_t Z_FAR = 32'sh7FFF_FFFF;

    localparam int RASTER_FB_W = 160;
    localparam int RASTER_FB_H = 120;

    // Framebuffer coordinate -> screen Q16.16 (integer part scaled up by 2^shift).
    function automatic q16_16_t fb_to_screen(input logic [7:0] v, input int shift);
        return q16_16_t'({24'd0, v} << (16 + shift));
    endfunction

endpackage

// File: rtl/raster_scheduler_depth_select.sv
// Purpose: tags returning evaluator results and keeps the nearest covering colour.
// Latency: result tagged EVAL_LAT cycles after enable; best_color_nxt is the
//          value best_color takes at the next edge. Backpressure: none.
// Ports: clear (pixel start, loads Z_FAR/clear_color), enable (issue this cycle),
//        eval_* (evaluator result), best_color_nxt (next-state colour).
module depth_select
    import fixed_pkg::*, color_pkg::*, render_pkg::*;
#(
    parameter int EVAL_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     enable,
    input  color12_t clear_color,
    input  logic     eval_inside,
    input  q16_16_t  eval_z,
    input  color12_t eval_color,
    output color12_t best_color_nxt
);

    // Bit EVAL_LAT-1 is high exactly in the cycle an issued triangle returns.
    logic [EVAL_LAT-1:0] tag_sr;
    q16_16_t             best_z;
    q16_16_t             best_z_nxt;
    color12_t            best_color;
    logic                update;

    // Strict signed less-than: on equal depth the earlier (lower index) result stays.
    assign update = tag_sr[EVAL_LAT-1] & eval_inside & (eval_z < best_z);

    always_comb begin
        best_z_nxt     = best_z;
        best_color_nxt = best_color;
        if (clear) begin
            best_z_nxt     = Z_FAR;
            best_color_nxt = clear_color;
        end else if (update) begin
            best_z_nxt     = eval_z;
            best_color_nxt = eval_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_sr     <= '0;
            best_z     <= Z_FAR;
            best_color <= '0;
        end else begin
            tag_sr     <= (tag_sr << 1) | EVAL_LAT'(enable);
            best_z     <= best_z_nxt;
            best_color <= best_color_nxt;
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// Purpose: walks the framebuffer in raster order, time-multiplexing one evaluator
//          over up to MAX_TRIS triangles and writing the nearest colour per pixel.
// Latency: N+EVAL_LAT+1 cycles per pixel (1 when N=0); no backpressure, frame_start
//          while busy is dropped and flagged on overrun.
// Ports: frame_start/tri_count/bg_color in; tri_idx/eval_p to evaluator;
//        eval_* back; fb_we/fb_x/fb_y/fb_color to framebuffer; busy/done/overrun status.
module raster_scheduler
    import fixed_pkg::*, color_pkg::*, render_pkg::*;
#(
    parameter int FB_WIDTH    = RASTER_FB_W,
    parameter int FB_HEIGHT   = RASTER_FB_H,
    parameter int MAX_TRIS    = 16,
    parameter int EVAL_LAT    = 2,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                          clk_100m,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [$clog2(MAX_TRIS+1)-1:0] tri_count,
    input  color12_t                      bg_color,
    output logic [$clog2(MAX_TRIS)-1:0]   tri_idx,
    output point2d_t                      eval_p,
    input  logic                          eval_inside,
    input  q16_16_t                       eval_z,
    input  color12_t                      eval_color,
    output logic                          fb_we,
    output logic [7:0]                    fb_x,
    output logic [6:0]                    fb_y,
    output logic [11:0]                   fb_color,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    localparam int CW = $clog2(MAX_TRIS + 1);
    localparam int IW = $clog2(MAX_TRIS);
    localparam int DW = $clog2(EVAL_LAT + 1);

    raster_state_t state;
    logic [CW-1:0] n_tris;
    color12_t      bg_q;
    logic [DW-1:0] drain_cnt;
    logic [7:0]    x;
    logic [6:0]    y;

    logic [CW-1:0] n_in;
    logic          accept;
    logic          last_px;
    logic          last_issue;
    logic          pix_start;
    logic [7:0]    x_nx;
    logic [6:0]    y_nx;
    color12_t      clr_color;
    color12_t      sel_color_nxt;

    assign n_in       = (tri_count > CW'(MAX_TRIS)) ? CW'(MAX_TRIS) : tri_count;
    assign accept     = (state == RS_IDLE) && frame_start;
    assign last_px    = (x == 8'(FB_WIDTH - 1)) && (y == 7'(FB_HEIGHT - 1));
    assign last_issue = (CW'(tri_idx) == n_tris - CW'(1));
    assign x_nx       = (x == 8'(FB_WIDTH - 1)) ? 8'd0 : x + 8'd1;
    assign y_nx       = (x == 8'(FB_WIDTH - 1)) ? y + 7'd1 : y;

    // Pixel start happens on the edge that leaves IDLE or leaves a non-final WRITE.
    // bg_color is not latched yet on the accept edge, so use the live input there.
    assign pix_start  = accept || ((state == RS_WRITE) && !last_px);
    assign clr_color  = accept ? bg_color : bg_q;

    // busy is high exactly when the FSM is outside IDLE.
    assign overrun    = frame_start & busy;
    assign fb_x       = x;
    assign fb_y       = y;

    depth_select #(
        .EVAL_LAT (EVAL_LAT)
    ) u_depth_select (
        .clk            (clk_100m),
        .rst            (rst),
        .clear          (pix_start),
        .enable         (state == RS_ISSUE),
        .clear_color    (clr_color),
        .eval_inside    (eval_inside),
        .eval_z         (eval_z),
        .eval_color     (eval_color),
        .best_color_nxt (sel_color_nxt)
    );

    // fb_color is loaded from the selector's next value so the final result
    // (returning in the last DRAIN cycle) is included in the written colour.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state     <= RS_IDLE;
            n_tris    <= '0;
            bg_q      <= '0;
            drain_cnt <= '0;
            x         <= '0;
            y         <= '0;
            tri_idx   <= '0;
            eval_p    <= '0;
            fb_we     <= 1'b0;
            fb_color  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fb_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                RS_IDLE: begin
                    if (frame_start) begin
                        n_tris  <= n_in;
                        bg_q    <= bg_color;
                        x       <= '0;
                        y       <= '0;
                        tri_idx <= '0;
                        eval_p  <= '0;
                        busy    <= 1'b1;
                        if (n_in == '0) begin
                            state    <= RS_WRITE;
                            fb_we    <= 1'b1;
                            fb_color <= sel_color_nxt;
                        end else begin
                            state <= RS_ISSUE;
                        end
                    end
                end
                RS_ISSUE: begin
                    if (last_issue) begin
                        state     <= RS_DRAIN;
                        tri_idx   <= '0;
                        drain_cnt <= '0;
                    end else begin
                        tri_idx <= tri_idx + IW'(1);
                    end
                end
                RS_DRAIN: begin
                    if (drain_cnt == DW'(EVAL_LAT - 1)) begin
                        state    <= RS_WRITE;
                        fb_we    <= 1'b1;
                        fb_color <= sel_color_nxt;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                RS_WRITE: begin
                    if (last_px) begin
                        state  <= RS_FINISH;
                        done   <= 1'b1;
                        x      <= '0;
                        y      <= '0;
                        eval_p <= '0;
                    end else begin
                        x        <= x_nx;
                        y        <= y_nx;
                        eval_p.x <= fb_to_screen(x_nx, SCALE_SHIFT);
                        eval_p.y <= fb_to_screen({1'b0, y_nx}, SCALE_SHIFT);
                        if (n_tris == '0) begin
                            state    <= RS_WRITE;
                            fb_we    <= 1'b1;
                            fb_color <= sel_color_nxt;
                        end else begin
                            state <= RS_ISSUE;
                        end
                    end
                end
                RS_FINISH: begin
                    state <= RS_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler on a reduced 8x4 framebuffer.
// A two-stage stub evaluator answers from a small triangle table.
// Each frame is checked for order, colour, write count and done timing.
module tb_raster_scheduler;
    import fixed_pkg::*;
    import color_pkg::*;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int MAXT = 4;
    localparam int LAT  = 2;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [2:0]  tri_count;
    color12_t    bg_color;
    logic [1:0]  tri_idx;
    point2d_t    eval_p;
    logic        eval_inside;
    q16_16_t     eval_z;
    color12_t    eval_color;
    logic        fb_we;
    logic [7:0]  fb_x;
    logic [6:0]  fb_y;
    logic [11:0] fb_color;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;

    // Stub triangle table: inside when fb x < thr_t[i].
    int          thr_t [MAXT];
    q16_16_t     z_t   [MAXT];
    logic [11:0] col_t [MAXT];

    raster_scheduler #(
        .FB_WIDTH    (W),
        .FB_HEIGHT   (H),
        .MAX_TRIS    (MAXT),
        .EVAL_LAT    (LAT),
        .SCALE_SHIFT (2)
    ) dut (
        .clk_100m    (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .tri_count   (tri_count),
        .bg_color    (bg_color),
        .tri_idx     (tri_idx),
        .eval_p      (eval_p),
        .eval_inside (eval_inside),
        .eval_z      (eval_z),
        .eval_color  (eval_color),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_color    (fb_color),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle evaluator pipeline.
    logic [1:0] idx_d1, idx_d2;
    logic [7:0] px_d1, px_d2;
    always_ff @(posedge clk) begin
        idx_d1 <= tri_idx;
        idx_d2 <= idx_d1;
        px_d1  <= eval_p.x[25:18];
        px_d2  <= px_d1;
    end
    always_comb begin
        eval_inside = (int'(px_d2) < thr_t[idx_d2]);
        eval_z      = z_t[idx_d2];
        eval_color  = col_t[idx_d2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_tri(input int i, input int thr, input q16_16_t z, input logic [11:0] c);
        thr_t[i] = thr;
        z_t[i]   = z;
        col_t[i] = c;
    endtask

    // Runs one frame; pixels with x < split expect exp_l, others exp_r.
    // If ovr_cyc > 2, frame_start is re-pulsed (and inputs disturbed) that cycle.
    task automatic run_frame(input string name, input int ppc, input logic [11:0] exp_l,
                             input logic [11:0] exp_r, input int split, input int ovr_cyc);
        int writes, errs, done_cyc, ex, ey, budget;
        logic [11:0] ec;
        writes = 0; errs = 0; done_cyc = -1; ex = 0; ey = 0;
        budget = 2 + W * H * ppc + 20;
        @(negedge clk);
        frame_start = 1'b1;
        #1 chk({name, "_ovr_idle"}, overrun, 0);
        for (int cyc = 2; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc == 2) frame_start = 1'b0;
            if (cyc == ovr_cyc) begin
                frame_start = 1'b1;
                tri_count   = 3'd0;
                bg_color    = 12'hFFF;
                #1 chk({name, "_overrun"}, overrun, 1);
            end else if (cyc == ovr_cyc + 1) begin
                frame_start = 1'b0;
            end
            if (fb_we) begin
                ec = (ex < split) ? exp_l : exp_r;
                if (fb_x !== 8'(ex) || fb_y !== 7'(ey) || fb_color !== ec) errs++;
                writes++;
                if (ex == W - 1) begin ex = 0; ey++; end
                else ex++;
            end
            if (!busy) errs++;
            if (done) begin
                if (fb_we) errs++;
                done_cyc = cyc;
                break;
            end
        end
        chk({name, "_writes"}, writes, W * H);
        chk({name, "_pix_errs"}, errs, 0);
        chk({name, "_done_cyc"}, done_cyc, 2 + W * H * ppc);
        @(negedge clk);
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int found, seen;
        rst = 1'b1; frame_start = 1'b0; tri_count = 3'd0; bg_color = 12'h000;
        for (int i = 0; i < MAXT; i++) set_tri(i, 0, 32'sd0, 12'h000);
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tri_idx", tri_idx, 0);
        chk("rst_eval_px", eval_p.x, 0);
        chk("rst_fb_color", fb_color, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // No triangles: background every cycle.
        tri_count = 3'd0; bg_color = 12'h123;
        run_frame("n0", 1, 12'h123, 12'h123, W, -1);

        // One triangle covering the left half.
        set_tri(0, 4, 32'sd0, 12'hF80);
        tri_count = 3'd1; bg_color = 12'h123;
        run_frame("n1", 4, 12'hF80, 12'h123, 4, -1);

        // Depth ordering: z = 30, 10, 10 -> second wins (strict <, tie keeps lower).
        set_tri(0, W, 32'sd30 <<< 16, 12'hA0A);
        set_tri(1, W, 32'sd10 <<< 16, 12'hB0B);
        set_tri(2, W, 32'sd10 <<< 16, 12'hC0C);
        tri_count = 3'd3;
        run_frame("tie", 6, 12'hB0B, 12'hB0B, W, -1);

        // Nothing inside although depths beat Z_FAR.
        set_tri(0, 0, -(32'sd5 <<< 16), 12'hF00);
        set_tri(1, 0, -(32'sd5 <<< 16), 12'h0F0);
        tri_count = 3'd2; bg_color = 12'h456;
        run_frame("outside", 5, 12'h456, 12'h456, W, -1);

        // tri_count 7 clamps to 4; the 4th triangle is the nearest.
        set_tri(0, W, 32'sd100 <<< 16, 12'hF00);
        set_tri(1, W, 32'sd100 <<< 16, 12'hF00);
        set_tri(2, W, 32'sd100 <<< 16, 12'hF00);
        set_tri(3, W, 32'sd1 <<< 16, 12'h0F0);
        tri_count = 3'd7; bg_color = 12'h123;
        run_frame("clamp", 7, 12'h0F0, 12'h0F0, W, -1);

        // Mid-frame frame_start plus tri_count/bg changes are ignored.
        set_tri(0, 4, 32'sd0, 12'hF80);
        tri_count = 3'd1; bg_color = 12'h123;
        run_frame("ovr", 4, 12'hF80, 12'h123, 4, 20);

        // Reset in the middle of a frame.
        tri_count = 3'd1; bg_color = 12'h123;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            if (fb_we && fb_x == 8'd5 && fb_y == 7'd2) begin found = 1; break; end
            @(negedge clk);
        end
        chk("rst_mid_reached", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_fb_we", fb_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_eval_py", eval_p.y, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (fb_we || busy || done) seen++;
        end
        chk("rst_mid_quiet", seen, 0);
        run_frame("post_rst", 4, 12'hF80, 12'h123, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/raster_scheduler.md
# raster_scheduler

Sequences per-frame rasterisation into the 160x120 write side of `double_framebuffer`. On each frame pulse it walks every framebuffer pixel in raster order. For each pixel it time-multiplexes one shared, pipelined `triangle_pixel_eval` across a list of up to MAX_TRIS triangles, keeps the nearest covering colour by depth, and issues one framebuffer write per pixel. It replaces the fixed two-evaluator "first inside wins" colouring in the top level with a scalable, depth-correct scheduler.

## Interface

Parameters:
- FB_WIDTH, 160, pixels per line
- FB_HEIGHT, 120, lines per frame
- MAX_TRIS, 16, triangle list capacity
- EVAL_LAT, 2, evaluator latency in cycles from `eval_p`/`tri_idx` to result; must be ≥1
- SCALE_SHIFT, 2, framebuffer-to-screen coordinate shift (160→640)

Ports:
- clk_100m  in  1  renderer clock; the only clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse, already synchronous to clk_100m
- tri_count  in  $clog2(MAX_TRIS+1)  number of valid triangles; sampled at frame start
- bg_color  in  color12_t  background colour; sampled at frame start
- tri_idx  out  $clog2(MAX_TRIS)  triangle index presented to triangle store and evaluator
- eval_p  out  point2d_t  sample point, Q16.16
- eval_inside  in  1  evaluator result, valid EVAL_LAT cycles after issue
- eval_z  in  q16_16_t  interpolated depth, signed
- eval_color  in  color12_t  interpolated colour
- fb_we  out  1  framebuffer write enable
- fb_x  out  8  write x
- fb_y  out  7  write y
- fb_color  out  12  {r,g,b}
- busy  out  1  high from the cycle after an accepted frame_start until done
- done  out  1  one-cycle pulse after the last write
- overrun  out  1  one-cycle pulse when frame_start arrives while busy

## Operation

- States:
  - IDLE: waits for frame_start.
  - ISSUE: issues one triangle per cycle, tri_idx 0..N-1.
  - DRAIN: EVAL_LAT cycles of waiting for the remaining results.
  - WRITE: one cycle; emits the pixel.
  - FINISH: one cycle; pulses done.
- IDLE + frame_start:
  - latch N=tri_count (values above MAX_TRIS clamp to MAX_TRIS) and bg_color;
  - set x=y=0;
  - go to ISSUE, or directly to WRITE if N=0.
- Pixel start: best_z ← Z_FAR (0x7FFF_FFFF), best_color ← latched bg.
- Sample point: eval_p.x = x << (16+SCALE_SHIFT), eval_p.y = y << (16+SCALE_SHIFT). Both are held constant for the whole pixel.
- Result accumulation:
  - An internal valid shift register of depth EVAL_LAT tags returning results. Tagged results must not depend on any evaluator valid signal.
  - A tagged result with eval_inside=1 and eval_z < best_z (signed, strict) updates best_z and best_color.
  - Ties keep the lower triangle index.
- WRITE: fb_we=1, fb_x=x, fb_y=y, fb_color=best_color.
- Advance after WRITE:
  - x increments; at x=FB_WIDTH-1, x wraps to 0 and y increments.
  - After (FB_WIDTH-1, FB_HEIGHT-1), go to FINISH.
  - Otherwise go to ISSUE (or WRITE if N=0).
- FINISH: done=1, then IDLE.
- frame_start outside IDLE is ignored and pulses overrun the same cycle. The current frame continues unchanged.
- Changes to tri_count or bg_color mid-frame have no effect.

## Timing

- Reset (asynchronous, immediate): all outputs are 0, state IDLE, eval_p=0, tri_idx=0, internal accumulator cleared. Reset mid-frame abandons the frame with no further writes.
- Cycles per pixel: N+EVAL_LAT+1 when N≥1; 1 when N=0.
- Frame length, frame_start edge to done: 1 + FB_WIDTH·FB_HEIGHT·(per-pixel cycles) + 1.
- First ISSUE (or WRITE) is the cycle after frame_start is sampled.
- fb_we is high exactly in WRITE cycles. There is no write in any other state.
- All outputs are registered. No combinational path from inputs to outputs except overrun.

## Structure

- Shared `render_pkg`:
  - `raster_state_t` enum;
  - `Z_FAR` constant;
  - `RASTER_FB_W` / `RASTER_FB_H` defaults.
- `render_pkg` reuses `fixed_pkg` (q16_16_t, point2d_t) and `color_pkg` (color12_t); it defines no new numeric types.
- One sub-module, `depth_select`: the valid-tag shift register plus best_z/best_color compare-and-update. It has clear/enable inputs driven by the FSM.

## Test plan

- N=0, bg=12'h123, frame_start pulse → 19200 consecutive fb_we cycles starting the next cycle, raster order, all colour 12'h123; done at cycle 19202; busy high throughout.
- N=1, EVAL_LAT=2, stub evaluator returns inside=1 for x<80, colour 12'hF80 → 4 cycles per pixel; left half 12'hF80, right half bg; done at cycle 76802.
- N=3, all inside, z = {30, 10, 10} (Q16.16), colours {A, B, C} → every pixel is written with B: strict less-than, and the tie keeps the lower index.
- Inside=0 for all triangles, with eval_z less than Z_FAR → bg written everywhere; checks that inside gates the update.
- frame_start pulsed mid-frame → overrun pulse that cycle; write count stays 19200; tri_count changed mid-frame is ignored.
- rst asserted at pixel (37,5) → fb_we, busy, done low immediately. The next frame_start restarts at (0,0).
